// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM encoding,
// latency counter width and the byte-to-word index slice position.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W   = 4;
  // Word index starts above the two byte-offset bits.
  localparam int IDX_LSB = 2;

  function automatic logic [CNT_W-1:0] latencyLoad(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous write, registered read and a
// synchronous clear of every word and the read register.
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one request at a time over valid/ready,
// serviced after LATENCY cycles with a one-cycle response pulse and a stall.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] count;
  logic             capWe;
  logic [31:0]      capAddr;
  logic [31:0]      capWdata;
  logic             respErrQ;
  logic             respIsData;
  logic             addrErr;
  logic             access;
  logic [31:0]      arrRdata;

  assign addrErr = (capAddr[IDX_LSB-1:0] != '0) | (|capAddr[31:ADDR_WIDTH+IDX_LSB]);
  assign access  = (state == BUSY) && (count == '0);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count      <= '0;
      respErrQ   <= 1'b0;
      respIsData <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) count <= latencyLoad(LATENCY);
      else if (state == BUSY && count != '0) count <= count - CNT_W'(1);
      if (access) begin
        respErrQ   <= addrErr;
        respIsData <= !capWe && !addrErr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      capWe    <= req_we;
      capAddr  <= req_addr;
      capWdata <= req_wdata;
    end
  end

  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) stateNext = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (count == '0) stateNext = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Rejected accesses never touch the array; the read register keeps its old
  // word, so data is zeroed here unless the last access was a good load.
  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) uArray (
    .clk   (clk),
    .clr   (clr),
    .we    (access && capWe && !addrErr),
    .re    (access && !capWe && !addrErr),
    .addr  (capAddr[ADDR_WIDTH+IDX_LSB-1:IDX_LSB]),
    .wdata (capWdata),
    .rdata (arrRdata)
  );

  assign resp_rdata = respIsData ? arrRdata : '0;
  assign resp_err   = respErrQ;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data accesses: accepts one load/store request over a valid/ready handshake and services it after a fixed access latency.
- Returns load data with a one-cycle response pulse and drives a stall so the pipeline can freeze while a request is outstanding.
- Replaces the single-cycle data memory wherever a multi-cycle memory is modelled.
- Owns a word-organised storage array of 2**ADDR_WIDTH 32-bit words.

Parameters:
ADDR_WIDTH, 10, word-index width (1024 words = 4 KB)
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_ready  output  1  responder can accept a request
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; request was rejected
stall  output  1  pipeline hold request

Behaviour:
- Reset: clr sampled high at a rising edge gives these results:
  - state = IDLE, counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Every storage word is cleared to 0.
  - Any in-flight request is aborted and its store is discarded.
  - clr has priority over all other inputs.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - If req_valid is high, the request is captured at the edge (we, addr, wdata), counter = LATENCY-1, and the next state is BUSY.
- BUSY:
  - req_ready = 0; request inputs are ignored.
  - If counter == 0, go to RESP; otherwise decrement the counter.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready = 0 in RESP; a request presented in RESP is taken in the following IDLE cycle.
- Latency: a request accepted at edge k produces resp_valid high in the cycle following edge k+LATENCY. Throughput is one request per LATENCY+2 cycles.
- Access: the array is accessed on the BUSY->RESP edge.
  - Store: writes wdata to word addr[ADDR_WIDTH+1:2].
  - Load: registers that word into resp_rdata.
  - A store followed by a load to the same address returns the new data.
- Errors: an access is rejected if addr[1:0] != 0 or any of addr[31:ADDR_WIDTH+2] is nonzero.
  - The store is suppressed.
  - resp_rdata = 0 and resp_err = 1 in the RESP cycle.
  - Timing is unchanged.
- resp_rdata and resp_err hold their values outside RESP; consumers qualify them with resp_valid.
- stall = (state == BUSY) | (state == IDLE & req_valid).
  - stall is 0 in RESP so the pipeline advances in the response cycle.
- Reset mid-BUSY: the pending store never commits and no resp_valid is produced.

Decomposition:
- Shared package:
  - state encoding (IDLE/BUSY/RESP, 2 bits).
  - counter width constant (4 bits).
  - word-aligned index slice helper constants.
- Sub-module dmem_array:
  - 2**ADDR_WIDTH x 32 storage.
  - Synchronous write enable.
  - Synchronous clear on clr.
  - Registered read.
- dmem_responder holds the FSM, counter, request capture registers and error check.

Test Plan:
1. Reset: hold clr 2 cycles, then idle -> req_ready=1, resp_valid=0, stall=0, resp_rdata=0; a load from 0x00000010 returns 0.
2. Store/load latency, LATENCY=2: store 0xDEADBEEF to 0x00000004, accepted at edge k -> resp_valid exactly in the cycle after edge k+2 with resp_err=0. A subsequent load from 0x4 returns 0xDEADBEEF. stall high from request presentation until the RESP cycle.
3. Back-to-back: req_valid held high with two loads -> second accepted in the IDLE cycle after RESP; responses spaced LATENCY+2 = 4 cycles apart; req_ready low in BUSY and RESP.
4. Errors:
   - Store to 0x00000006 -> resp_err=1, rdata=0; a load from 0x4 is unchanged.
   - Load from 0x00001000 (ADDR_WIDTH=10) -> resp_err=1.
5. Reset mid-operation: store 0x12345678 to 0x8, assert clr during BUSY -> no resp_valid; a later load from 0x8 returns 0.
6. LATENCY=1 instance: load accepted at edge k -> resp_valid in the cycle after edge k+1; last word 0x00000FFC is writable and readable.
